// File: rtl/spi_display.sv
// Write-only SPI master (mode 0) for small display controllers.
// Pops {dc, byte} words from a show-ahead queue and shifts each byte out MSB-first, paced by `step`.
module spi_display (
  input  logic       clock,
  input  logic       reset,
  input  logic       step,
  input  logic       in_dc,
  input  logic [7:0] in_data,
  output logic       get,
  input  logic       empty,
  output logic       spi_cs_n,
  output logic       spi_clock,
  output logic       spi_dc,
  output logic       spi_mosi
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2,
    S_END  = 2'd3
  } state_t;

  state_t     state_r, state_s;
  logic [6:0] shift_r, shift_s;
  logic [2:0] cnt_r, cnt_s;
  logic       cs_n_r, cs_n_s;
  logic       sclk_r, sclk_s;
  logic       dc_r, dc_s;
  logic       mosi_r, mosi_s;
  logic       load_s;

  // A word is taken only on a step edge, from IDLE or END, when the queue has one.
  assign load_s = step && !empty && ((state_r == S_IDLE) || (state_r == S_END));

  // Pop strobe is qualified by reset so it stays low while reset is held.
  assign get = load_s && reset;

  assign spi_cs_n  = cs_n_r;
  assign spi_clock = sclk_r;
  assign spi_dc    = dc_r;
  assign spi_mosi  = mosi_r;

  // Next-state and next-output logic; everything holds unless step is high.
  always_comb begin
    state_s = state_r;
    shift_s = shift_r;
    cnt_s   = cnt_r;
    cs_n_s  = cs_n_r;
    sclk_s  = sclk_r;
    dc_s    = dc_r;
    mosi_s  = mosi_r;
    if (step) begin
      case (state_r)
        S_IDLE: begin
          if (load_s) begin
            shift_s = in_data[6:0];
            cs_n_s  = 1'b0;
            dc_s    = in_dc;
            mosi_s  = in_data[7];
            sclk_s  = 1'b0;
            cnt_s   = 3'd7;
            state_s = S_HIGH;
          end else begin
            state_s = S_IDLE;
          end
        end
        S_HIGH: begin
          sclk_s = 1'b1;
          if (cnt_r == 3'd0) begin
            state_s = S_END;
          end else begin
            state_s = S_LOW;
          end
        end
        S_LOW: begin
          sclk_s  = 1'b0;
          cnt_s   = cnt_r - 3'd1;
          mosi_s  = shift_r[6];
          shift_s = {shift_r[5:0], 1'b0};
          state_s = S_HIGH;
        end
        S_END: begin
          sclk_s = 1'b0;
          // Back-to-back load keeps CS asserted between bytes.
          if (load_s) begin
            shift_s = in_data[6:0];
            cs_n_s  = 1'b0;
            dc_s    = in_dc;
            mosi_s  = in_data[7];
            cnt_s   = 3'd7;
            state_s = S_HIGH;
          end else begin
            cs_n_s  = 1'b1;
            state_s = S_IDLE;
          end
        end
        default: begin
          state_s = S_IDLE;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State and output registers with asynchronous reset to the idle bus state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
      shift_r <= 7'd0;
      cnt_r   <= 3'd0;
      cs_n_r  <= 1'b1;
      sclk_r  <= 1'b0;
      dc_r    <= 1'b0;
      mosi_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      shift_r <= shift_s;
      cnt_r   <= cnt_s;
      cs_n_r  <= cs_n_s;
      sclk_r  <= sclk_s;
      dc_r    <= dc_s;
      mosi_r  <= mosi_s;
    end
  end

endmodule

// File: tb/tb_spi_display.sv
// Directed bench for spi_display: a show-ahead queue model feeds words, a monitor
// records MOSI/DC on each SCLK rise, and directed steps check against fixed values.
module tb_spi_display;

  logic       clock = 1'b0;
  logic       reset;
  logic       step;
  logic       in_dc;
  logic [7:0] in_data;
  logic       get;
  logic       empty;
  logic       spi_cs_n;
  logic       spi_clock;
  logic       spi_dc;
  logic       spi_mosi;

  int checks = 0;
  int errors = 0;

  // Show-ahead queue model
  logic [8:0] q [0:15];
  logic [3:0] head = 4'd0;
  logic [4:0] qcount = 5'd0;

  // Monitor state
  logic       bits  [0:255];
  logic       dcbit [0:255];
  int         rises = 0;
  int         gets = 0;
  int         cs_rises = 0;
  logic       last_get;
  int         base;
  int         gbase;
  int         cbase;

  spi_display dut (
    .clock    (clock),
    .reset    (reset),
    .step     (step),
    .in_dc    (in_dc),
    .in_data  (in_data),
    .get      (get),
    .empty    (empty),
    .spi_cs_n (spi_cs_n),
    .spi_clock(spi_clock),
    .spi_dc   (spi_dc),
    .spi_mosi (spi_mosi)
  );

  always #5 clock = ~clock;

  assign empty   = ({1'b0, head} >= qcount);
  assign in_dc   = q[head][8];
  assign in_data = q[head][7:0];

  always @(posedge clock) begin
    if (get) begin
      head <= head + 4'd1;
      gets <= gets + 1;
    end
  end

  always @(posedge spi_clock) begin
    bits[rises[7:0]]  = spi_mosi;
    dcbit[rises[7:0]] = spi_dc;
    rises = rises + 1;
  end

  always @(posedge spi_cs_n) cs_rises = cs_rises + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rx_byte(input int b);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[7-i] = bits[(b + i) % 256];
    return v;
  endfunction

  // One step strobe, then three idle clocks; get is sampled inside the step cycle.
  task automatic pulse_step();
    @(negedge clock);
    step = 1'b1;
    #1 last_get = get;
    @(negedge clock);
    step = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic pulse_steps(input int n);
    for (int i = 0; i < n; i++) pulse_step();
  endtask

  task automatic check_idle_bus(input string tag);
    check({tag, "_cs_n"}, {31'd0, spi_cs_n}, 32'd1);
    check({tag, "_sclk"}, {31'd0, spi_clock}, 32'd0);
    check({tag, "_dc"}, {31'd0, spi_dc}, 32'd0);
    check({tag, "_mosi"}, {31'd0, spi_mosi}, 32'd0);
    check({tag, "_get"}, {31'd0, get}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) q[i] = 9'd0;
    reset = 1'b0;
    step  = 1'b0;
    last_get = 1'b0;

    // Reset held with a word waiting and step toggling
    q[0] = {1'b0, 8'hA5};
    qcount = 5'd1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      step = ~step;
      #1 check_idle_bus("reset");
    end
    @(negedge clock);
    step = 1'b0;
    check("reset_no_pop", gets, 32'd0);
    reset = 1'b1;

    // Single command byte A5, step every 4th clock
    pulse_step();
    check("single_get_first_step", {31'd0, last_get}, 32'd1);
    check("single_cs_low", {31'd0, spi_cs_n}, 32'd0);
    check("single_dc", {31'd0, spi_dc}, 32'd0);
    pulse_steps(15);
    check("single_cs_still_low", {31'd0, spi_cs_n}, 32'd0);
    check("single_rises", rises, 32'd8);
    check("single_byte", {24'd0, rx_byte(0)}, 32'hA5);
    pulse_step();
    check("single_cs_rise_step17", {31'd0, spi_cs_n}, 32'd1);
    check("single_sclk_idle", {31'd0, spi_clock}, 32'd0);
    check("single_gets", gets, 32'd1);

    // Back-to-back AF(cmd), 01(data), FF(data)
    base = rises; gbase = gets; cbase = cs_rises;
    q[1] = {1'b0, 8'hAF};
    q[2] = {1'b1, 8'h01};
    q[3] = {1'b1, 8'hFF};
    qcount = 5'd4;
    pulse_steps(48);
    check("b2b_cs_continuous", cs_rises - cbase, 32'd0);
    check("b2b_cs_low", {31'd0, spi_cs_n}, 32'd0);
    check("b2b_rises", rises - base, 32'd24);
    check("b2b_gets", gets - gbase, 32'd3);
    check("b2b_byte0", {24'd0, rx_byte(base)}, 32'hAF);
    check("b2b_byte1", {24'd0, rx_byte(base + 8)}, 32'h01);
    check("b2b_byte2", {24'd0, rx_byte(base + 16)}, 32'hFF);
    check("b2b_dc_rise8", {31'd0, dcbit[(base + 7) % 256]}, 32'd0);
    check("b2b_dc_rise9", {31'd0, dcbit[(base + 8) % 256]}, 32'd1);
    pulse_step();
    check("b2b_cs_end", {31'd0, spi_cs_n}, 32'd1);

    // Step stall mid-byte on 3C (data)
    base = rises;
    q[4] = {1'b1, 8'h3C};
    qcount = 5'd5;
    pulse_steps(5);
    check("stall_rises_before", rises - base, 32'd2);
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      check("stall_get", {31'd0, get}, 32'd0);
      check("stall_sclk", {31'd0, spi_clock}, 32'd0);
      check("stall_mosi", {31'd0, spi_mosi}, 32'd1);
      check("stall_cs", {31'd0, spi_cs_n}, 32'd0);
      check("stall_dc", {31'd0, spi_dc}, 32'd1);
    end
    check("stall_rises_frozen", rises - base, 32'd2);
    pulse_steps(12);
    check("stall_byte", {24'd0, rx_byte(base)}, 32'h3C);
    check("stall_cs_end", {31'd0, spi_cs_n}, 32'd1);

    // Empty queue: no pops, CS stays high; then refill while idle
    gbase = gets;
    for (int i = 0; i < 10; i++) begin
      pulse_step();
      check("empty_no_get", {31'd0, last_get}, 32'd0);
      check("empty_cs", {31'd0, spi_cs_n}, 32'd1);
    end
    check("empty_gets", gets - gbase, 32'd0);
    base = rises;
    q[5] = {1'b0, 8'h81};
    qcount = 5'd6;
    pulse_step();
    check("refill_get", {31'd0, last_get}, 32'd1);
    check("refill_cs", {31'd0, spi_cs_n}, 32'd0);
    pulse_steps(16);
    check("refill_byte", {24'd0, rx_byte(base)}, 32'h81);
    check("refill_cs_end", {31'd0, spi_cs_n}, 32'd1);

    // Reset mid-byte after 3 SCLK rises; next word must start from its MSB
    base = rises;
    q[6] = {1'b1, 8'hC3};
    q[7] = {1'b0, 8'h5A};
    qcount = 5'd8;
    pulse_steps(6);
    check("rst_mid_rises", rises - base, 32'd3);
    reset = 1'b0;
    #1 check_idle_bus("rst_mid");
    repeat (2) @(negedge clock);
    reset = 1'b1;
    gbase = gets;
    base = rises;
    pulse_steps(17);
    check("rst_after_gets", gets - gbase, 32'd1);
    check("rst_after_rises", rises - base, 32'd8);
    check("rst_after_byte", {24'd0, rx_byte(base)}, 32'h5A);
    check("rst_after_dc", {31'd0, dcbit[base % 256]}, 32'd0);
    check("rst_after_cs", {31'd0, spi_cs_n}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
